// File: rtl/ex_branch_issue.sv
// In-order branch issue queue: buffers decoded branches, snoops the flag broadcast bus and
// issues resolved heads to the branch port. Optional: MIST1032SA_BRANCH_ISSUE_BYPASS_EN.
module ex_branch_issue #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned DEPTH_N = 2
) (
  input  logic               iCLOCK,
  input  logic               inRESET,
  input  logic               iFREE_RESTART,
  input  logic               iENT_VALID,
  output logic               oENT_FULL,
  input  logic [5:0]         iENT_COMMIT_TAG,
  input  logic [4:0]         iENT_CMD,
  input  logic [3:0]         iENT_CC,
  input  logic [31:0]        iENT_SOURCE,
  input  logic [31:0]        iENT_PC,
  input  logic               iENT_FLAG_READY,
  input  logic [4:0]         iENT_FLAG,
  input  logic [5:0]         iENT_FLAG_TAG,
  input  logic               iFLAGS_VALID,
  input  logic [5:0]         iFLAGS_COMMIT_TAG,
  input  logic [4:0]         iFLAGS_DATA,
  output logic               oEX_BRANCH_VALID,
  output logic [5:0]         oEX_BRANCH_COMMIT_TAG,
  output logic [4:0]         oEX_BRANCH_CMD,
  output logic [3:0]         oEX_BRANCH_CC,
  output logic [4:0]         oEX_BRANCH_FLAG,
  output logic [31:0]        oEX_BRANCH_SOURCE,
  output logic [31:0]        oEX_BRANCH_PC,
  input  logic               iEX_BRANCH_LOCK,
  output logic [DEPTH_N:0]   oCOUNT
);

  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [DEPTH-1:0]   ready_q, ready_d;
  logic [4:0]         flag_q [DEPTH];
  logic [4:0]         flag_d [DEPTH];
  logic [5:0]         ftag_q [DEPTH];
  logic [5:0]         ftag_d [DEPTH];
  logic [5:0]         ctag_q [DEPTH];
  logic [4:0]         cmd_q  [DEPTH];
  logic [3:0]         cc_q   [DEPTH];
  logic [31:0]        src_q  [DEPTH];
  logic [31:0]        pc_q   [DEPTH];
  logic [DEPTH_N-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DEPTH_N:0]   count_q, count_d;

  logic               out_valid_q, out_valid_d;
  logic [5:0]         out_ctag_q, out_ctag_d;
  logic [4:0]         out_cmd_q, out_cmd_d;
  logic [3:0]         out_cc_q, out_cc_d;
  logic [4:0]         out_flag_q, out_flag_d;
  logic [31:0]        out_src_q, out_src_d;
  logic [31:0]        out_pc_q, out_pc_d;

  logic               full, enq, iss, ent_hit, head_rdy;
  logic [4:0]         head_flag;

  always_comb begin
    full    = (count_q == (DEPTH_N + 1)'(DEPTH));
    enq     = iENT_VALID && !full && !iFREE_RESTART;
    ent_hit = iFLAGS_VALID && (iFLAGS_COMMIT_TAG == iENT_FLAG_TAG);
`ifdef MIST1032SA_BRANCH_ISSUE_BYPASS_EN
    // A live broadcast for the head counts as resolved this cycle.
    head_rdy  = valid_q[rptr_q] && (ready_q[rptr_q] ||
                (iFLAGS_VALID && (iFLAGS_COMMIT_TAG == ftag_q[rptr_q])));
    head_flag = ready_q[rptr_q] ? flag_q[rptr_q] : iFLAGS_DATA;
`else
    head_rdy  = valid_q[rptr_q] && ready_q[rptr_q];
    head_flag = flag_q[rptr_q];
`endif
    iss = head_rdy && !iEX_BRANCH_LOCK && !iFREE_RESTART;
  end

  always_comb begin
    valid_d     = valid_q;
    ready_d     = ready_q;
    flag_d      = flag_q;
    ftag_d      = ftag_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    out_valid_d = 1'b0;
    out_ctag_d  = out_ctag_q;
    out_cmd_d   = out_cmd_q;
    out_cc_d    = out_cc_q;
    out_flag_d  = out_flag_q;
    out_src_d   = out_src_q;
    out_pc_d    = out_pc_q;
    if (iFREE_RESTART) begin
      valid_d = '0;
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && !ready_q[i] && iFLAGS_VALID && (ftag_q[i] == iFLAGS_COMMIT_TAG)) begin
          ready_d[i] = 1'b1;
          flag_d[i]  = iFLAGS_DATA;
        end
      end
      if (enq) begin
        valid_d[wptr_q] = 1'b1;
        ready_d[wptr_q] = iENT_FLAG_READY || ent_hit;
        flag_d[wptr_q]  = iENT_FLAG_READY ? iENT_FLAG : iFLAGS_DATA;
        ftag_d[wptr_q]  = iENT_FLAG_TAG;
        wptr_d          = wptr_q + 1'b1;
      end
      if (iss) begin
        valid_d[rptr_q] = 1'b0;
        rptr_d          = rptr_q + 1'b1;
        out_valid_d     = 1'b1;
        out_ctag_d      = ctag_q[rptr_q];
        out_cmd_d       = cmd_q[rptr_q];
        out_cc_d        = cc_q[rptr_q];
        out_flag_d      = head_flag;
        out_src_d       = src_q[rptr_q];
        out_pc_d        = pc_q[rptr_q];
      end
      if (enq && !iss) begin
        count_d = count_q + 1'b1;
      end else if (iss && !enq) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      valid_q     <= '0;
      ready_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        flag_q[i] <= '0;
        ftag_q[i] <= '0;
      end
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_ctag_q  <= '0;
      out_cmd_q   <= '0;
      out_cc_q    <= '0;
      out_flag_q  <= '0;
      out_src_q   <= '0;
      out_pc_q    <= '0;
    end else begin
      valid_q     <= valid_d;
      ready_q     <= ready_d;
      flag_q      <= flag_d;
      ftag_q      <= ftag_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_ctag_q  <= out_ctag_d;
      out_cmd_q   <= out_cmd_d;
      out_cc_q    <= out_cc_d;
      out_flag_q  <= out_flag_d;
      out_src_q   <= out_src_d;
      out_pc_q    <= out_pc_d;
    end
  end

  // Payload is qualified by valid_q, so it needs no reset.
  always_ff @(posedge iCLOCK) begin
    if (enq) begin
      ctag_q[wptr_q] <= iENT_COMMIT_TAG;
      cmd_q[wptr_q]  <= iENT_CMD;
      cc_q[wptr_q]   <= iENT_CC;
      src_q[wptr_q]  <= iENT_SOURCE;
      pc_q[wptr_q]   <= iENT_PC;
    end
  end

  assign oENT_FULL             = full;
  assign oCOUNT                = count_q;
  assign oEX_BRANCH_VALID      = out_valid_q;
  assign oEX_BRANCH_COMMIT_TAG = out_ctag_q;
  assign oEX_BRANCH_CMD        = out_cmd_q;
  assign oEX_BRANCH_CC         = out_cc_q;
  assign oEX_BRANCH_FLAG       = out_flag_q;
  assign oEX_BRANCH_SOURCE     = out_src_q;
  assign oEX_BRANCH_PC         = out_pc_q;

endmodule

// File: tb/tb_ex_branch_issue.sv
// Scoreboard bench for ex_branch_issue: enqueues push expected issues, a negedge monitor
// pops and compares every issue pulse.
module tb_ex_branch_issue;

  typedef struct packed {
    logic [5:0]  tag;
    logic [4:0]  cmd;
    logic [3:0]  cc;
    logic [4:0]  flag;
    logic [31:0] src;
    logic [31:0] pc;
  } iss_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        restart = 1'b0;
  logic        ent_valid = 1'b0;
  logic        ent_full;
  logic [5:0]  ent_tag = '0;
  logic [4:0]  ent_cmd = '0;
  logic [3:0]  ent_cc = '0;
  logic [31:0] ent_src = '0;
  logic [31:0] ent_pc = '0;
  logic        ent_fready = 1'b0;
  logic [4:0]  ent_flag = '0;
  logic [5:0]  ent_ftag = '0;
  logic        fl_valid = 1'b0;
  logic [5:0]  fl_tag = '0;
  logic [4:0]  fl_data = '0;
  logic        br_valid;
  logic [5:0]  br_tag;
  logic [4:0]  br_cmd;
  logic [3:0]  br_cc;
  logic [4:0]  br_flag;
  logic [31:0] br_src;
  logic [31:0] br_pc;
  logic        lock = 1'b0;
  logic [2:0]  count;

  int   n_cmp = 0;
  int   n_err = 0;
  iss_t exp_q[$];

  ex_branch_issue #(.DEPTH(4), .DEPTH_N(2)) dut (
    .iCLOCK(clk), .inRESET(rst_n), .iFREE_RESTART(restart),
    .iENT_VALID(ent_valid), .oENT_FULL(ent_full), .iENT_COMMIT_TAG(ent_tag),
    .iENT_CMD(ent_cmd), .iENT_CC(ent_cc), .iENT_SOURCE(ent_src), .iENT_PC(ent_pc),
    .iENT_FLAG_READY(ent_fready), .iENT_FLAG(ent_flag), .iENT_FLAG_TAG(ent_ftag),
    .iFLAGS_VALID(fl_valid), .iFLAGS_COMMIT_TAG(fl_tag), .iFLAGS_DATA(fl_data),
    .oEX_BRANCH_VALID(br_valid), .oEX_BRANCH_COMMIT_TAG(br_tag), .oEX_BRANCH_CMD(br_cmd),
    .oEX_BRANCH_CC(br_cc), .oEX_BRANCH_FLAG(br_flag), .oEX_BRANCH_SOURCE(br_src),
    .oEX_BRANCH_PC(br_pc), .iEX_BRANCH_LOCK(lock), .oCOUNT(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present one enqueue for a single edge; optionally record the expected issue.
  task automatic enq(input logic [5:0] tag, input logic [4:0] cmd, input logic [3:0] cc,
                     input logic [31:0] src, input logic [31:0] pc, input logic frdy,
                     input logic [4:0] flag, input logic [5:0] ftag, input logic push,
                     input logic [4:0] exp_flag);
    iss_t e;
    ent_valid = 1'b1; ent_tag = tag; ent_cmd = cmd; ent_cc = cc; ent_src = src;
    ent_pc = pc; ent_fready = frdy; ent_flag = flag; ent_ftag = ftag;
    if (push) begin
      e = '{tag: tag, cmd: cmd, cc: cc, flag: exp_flag, src: src, pc: pc};
      exp_q.push_back(e);
    end
    cyc();
    ent_valid = 1'b0;
  endtask

  // Monitor: every issue pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    iss_t a;
    iss_t e;
    if (rst_n && br_valid) begin
      a = '{tag: br_tag, cmd: br_cmd, cc: br_cc, flag: br_flag, src: br_src, pc: br_pc};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL issue_unexpected: got tag 0x%0h pc 0x%0h with nothing expected",
                 br_tag, br_pc);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          n_err++;
          $display("FAIL issue_fields: got %h expected %h", a, e);
        end
      end
    end
  end

  initial begin
    bit seen;
    #12;
    chk("rst_valid", 64'(br_valid), 64'd0);
    chk("rst_data", {br_tag, br_cmd, br_cc, br_flag, br_src[15:0]}, 64'd0);
    chk("rst_pc", 64'(br_pc), 64'd0);
    chk("rst_full", 64'(ent_full), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    rst_n = 1'b1;
    cyc();

    // Basic: ready entry, 2-cycle latency.
    enq(6'h05, 5'h02, 4'hE, 32'h20, 32'h100, 1'b1, 5'h00, 6'h00, 1'b1, 5'h00);
    chk("t1_count1", 64'(count), 64'd1);
    chk("t1_valid_early", 64'(br_valid), 64'd0);
    cyc();
    chk("t1_valid", 64'(br_valid), 64'd1);
    chk("t1_count0", 64'(count), 64'd0);
    cyc();
    chk("t1_pulse_end", 64'(br_valid), 64'd0);

    // Waiting head blocks a younger ready entry.
    enq(6'h10, 5'h03, 4'h1, 32'h40, 32'h200, 1'b0, 5'h00, 6'h0A, 1'b1, 5'h01);
    enq(6'h11, 5'h04, 4'h2, 32'h44, 32'h204, 1'b1, 5'h03, 6'h00, 1'b1, 5'h03);
    repeat (3) cyc();
    chk("t2_blocked", 64'(br_valid), 64'd0);
    chk("t2_count2", 64'(count), 64'd2);
    fl_valid = 1'b1; fl_tag = 6'h0A; fl_data = 5'h01;
    cyc();
    fl_valid = 1'b0;
    repeat (4) cyc();
    chk("t2_drained", 64'(count), 64'd0);

    // Full with lock held; fifth enqueue refused.
    lock = 1'b1;
    for (int i = 0; i < 5; i++) begin
      enq(6'(6'h20 + i), 5'h05, 4'(i), 32'(32'h1000 + i), 32'(32'h300 + 4 * i), 1'b1,
          5'(i), 6'h00, (i < 4), 5'(i));
      if (i == 2) chk("t3_not_full", 64'(ent_full), 64'd0);
      if (i == 3) chk("t3_full", 64'(ent_full), 64'd1);
    end
    chk("t3_count4", 64'(count), 64'd4);
    chk("t3_locked", 64'(br_valid), 64'd0);
    lock = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t3_burst", 64'(br_valid), 64'd1);
    end
    cyc();
    chk("t3_burst_end", 64'(br_valid), 64'd0);
    chk("t3_empty", 64'(count), 64'd0);

    // Same-cycle capture at enqueue.
    fl_valid = 1'b1; fl_tag = 6'h22; fl_data = 5'h10;
    enq(6'h30, 5'h06, 4'h3, 32'h50, 32'h400, 1'b0, 5'h00, 6'h22, 1'b1, 5'h10);
    fl_valid = 1'b0;
    repeat (3) cyc();
    chk("t4_drained", 64'(count), 64'd0);

    // Restart flushes queue and the coincident enqueue.
    lock = 1'b1;
    for (int i = 0; i < 3; i++)
      enq(6'(6'h38 + i), 5'h07, 4'h4, 32'h60, 32'h500, 1'b1, 5'h02, 6'h00, 1'b0, 5'h00);
    chk("t5_count3", 64'(count), 64'd3);
    restart = 1'b1;
    enq(6'h3F, 5'h07, 4'h4, 32'h60, 32'h510, 1'b1, 5'h02, 6'h00, 1'b0, 5'h00);
    restart = 1'b0;
    lock = 1'b0;
    chk("t5_flushed", 64'(count), 64'd0);
    cyc();
    chk("t5_no_issue", 64'(br_valid), 64'd0);
    enq(6'h01, 5'h08, 4'h5, 32'h70, 32'h600, 1'b1, 5'h04, 6'h00, 1'b1, 5'h04);
    repeat (3) cyc();
    chk("t5_after", 64'(count), 64'd0);

    // Asynchronous reset while an issue pulse is presented.
    enq(6'h02, 5'h09, 4'h6, 32'h80, 32'h700, 1'b1, 5'h05, 6'h00, 1'b0, 5'h00);
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      if (br_valid) seen = 1'b1;
      else cyc();
    end
    chk("t6_saw_issue", 64'(seen), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_valid0", 64'(br_valid), 64'd0);
    chk("t6_data0", {br_tag, br_cmd, br_cc, br_flag, br_src[15:0]}, 64'd0);
    chk("t6_pc0", 64'(br_pc), 64'd0);
    chk("t6_count0", 64'(count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk("t6_empty", 64'(count), 64'd0);
    chk("t6_not_full", 64'(ent_full), 64'd0);

    repeat (3) cyc();
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
